// File: rtl/mnist_pkg.sv
// Shared types and helpers for the MNIST dense-layer engine.
// Holds the engine state encoding, width defaults and the packed-slice macro.
`ifndef MNIST_SLICE
`define MNIST_SLICE(idx, w) ((idx)*(w)) +: (w)
`endif

package mnist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_ARGMAX,
    S_DONE
  } state_t;

  localparam int DEF_NUM_IN      = 784;
  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_WEIGHT_W    = 8;
  localparam int DEF_ACC_W       = 32;

  // Never returns less than 1 so single-entry ranges still get a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mnist_dense_engine_argmax.sv
// Sequential signed argmax: one class per step, strict greater-than so ties keep the lowest index.
// The first step of a scan unconditionally takes class 0; best_idx holds between scans.
module argmax_seq
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int ACC_W       = DEF_ACC_W
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            clear,
  input  logic                            step,
  input  logic [NUM_CLASSES*ACC_W-1:0]    scores,
  output logic                            last,
  output logic [clog2(NUM_CLASSES)-1:0]   best_idx
);

  localparam int IW = clog2(NUM_CLASSES);

  logic [IW-1:0]           cnt;
  logic signed [ACC_W-1:0] best_val;
  logic signed [ACC_W-1:0] cand;

  assign cand = scores[`MNIST_SLICE(cnt, ACC_W)];
  assign last = step && (cnt == IW'(NUM_CLASSES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (step) begin
      if ((cnt == '0) || (cand > best_val)) begin
        best_val <= cand;
        best_idx <= cnt;
      end
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mnist_dense_engine.sv
// Dense-layer engine: streams NUM_IN pixels/weight rows, accumulates NUM_CLASSES scores in parallel,
// optional ReLU, then a sequential argmax. start/busy/done handshake; latency NUM_IN+NUM_CLASSES+2.
module mnist_dense_engine
  import mnist_pkg::*;
#(
  parameter int NUM_IN      = DEF_NUM_IN,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WEIGHT_W    = DEF_WEIGHT_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int RELU        = 0
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [clog2(NUM_IN)-1:0]          pix_addr,
  input  logic [DATA_W-1:0]                 pix_data,
  input  logic [NUM_CLASSES*WEIGHT_W-1:0]   w_row,
  output logic [NUM_CLASSES*ACC_W-1:0]      scores,
  output logic [clog2(NUM_CLASSES)-1:0]     class_idx
);

  localparam int AW     = clog2(NUM_IN);
  localparam int PROD_W = DATA_W + WEIGHT_W + 1;
  localparam int EXT_W  = (ACC_W > PROD_W) ? ACC_W : PROD_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_IN - 1);

  state_t           state_q, state_d;
  logic             dat_vld;
  logic             accept;
  logic             scan_clear;
  logic             scan_step;
  logic             scan_last;
  logic [ACC_W-1:0] acc     [NUM_CLASSES];
  logic [ACC_W-1:0] prod    [NUM_CLASSES];
  logic [ACC_W-1:0] score_q [NUM_CLASSES];

  assign accept     = (state_q == S_IDLE) && start;
  // DRAIN exits once the last returning beat has been absorbed; scores latch on that edge.
  assign scan_clear = (state_q == S_DRAIN) && !dat_vld;
  assign scan_step  = (state_q == S_ARGMAX);
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_ARGMAX);
  assign done       = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (pix_addr == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN:  if (!dat_vld) state_d = S_ARGMAX;
      S_ARGMAX: if (scan_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Product is exact in EXT_W bits; only the low ACC_W bits feed the wrapping accumulator.
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_mac
    logic signed [EXT_W-1:0] px_ext;
    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] p_full;
    assign px_ext  = EXT_W'($signed({1'b0, pix_data}));
    assign w_ext   = EXT_W'($signed(w_row[`MNIST_SLICE(c, WEIGHT_W)]));
    assign p_full  = px_ext * w_ext;
    assign prod[c] = p_full[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_addr <= '0;
      dat_vld  <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc[c]     <= '0;
        score_q[c] <= '0;
      end
    end else begin
      dat_vld <= (state_q == S_RUN);
      if (state_q == S_RUN) pix_addr <= (pix_addr == LAST_ADDR) ? '0 : pix_addr + 1'b1;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (accept)       acc[c] <= '0;
        else if (dat_vld) acc[c] <= acc[c] + prod[c];
        if (scan_clear) score_q[c] <= ((RELU != 0) && acc[c][ACC_W-1]) ? '0 : acc[c];
      end
    end
  end

  always_comb begin
    scores = '0;
    for (int c = 0; c < NUM_CLASSES; c++) scores[`MNIST_SLICE(c, ACC_W)] = score_q[c];
  end

  argmax_seq #(
    .NUM_CLASSES (NUM_CLASSES),
    .ACC_W       (ACC_W)
  ) u_argmax (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (scan_clear),
    .step     (scan_step),
    .scores   (scores),
    .last     (scan_last),
    .best_idx (class_idx)
  );

endmodule

// File: tb/tb_mnist_dense_engine.sv
// Directed bench for mnist_dense_engine: three small instances (plain, ReLU, 8-bit accumulator)
// share one pixel/weight memory; each scenario task checks its own results inline.
module tb_mnist_dense_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [2:0]  start_v;
  logic [2:0]  done_v;
  logic [2:0]  busy_v;
  logic [1:0]  pa0, pa1, pa2;
  logic [7:0]  pd0, pd1, pd2;
  logic [23:0] wr0, wr1, wr2;
  logic [95:0] sc0, sc1;
  logic [23:0] sc2;
  logic [1:0]  ci0, ci1, ci2;

  logic [7:0]  pix_mem [4];
  logic [23:0] w_mem   [4];

  int total = 0;
  int bad   = 0;

  always @(posedge clk) begin
    pd0 <= pix_mem[pa0]; wr0 <= w_mem[pa0];
    pd1 <= pix_mem[pa1]; wr1 <= w_mem[pa1];
    pd2 <= pix_mem[pa2]; wr2 <= w_mem[pa2];
  end

  mnist_dense_engine #(.NUM_IN(4), .NUM_CLASSES(3), .DATA_W(8), .WEIGHT_W(8), .ACC_W(32), .RELU(0)) dut0 (
    .clk(clk), .resetn(resetn), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pix_addr(pa0), .pix_data(pd0), .w_row(wr0), .scores(sc0), .class_idx(ci0));

  mnist_dense_engine #(.NUM_IN(4), .NUM_CLASSES(3), .DATA_W(8), .WEIGHT_W(8), .ACC_W(32), .RELU(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pix_addr(pa1), .pix_data(pd1), .w_row(wr1), .scores(sc1), .class_idx(ci1));

  mnist_dense_engine #(.NUM_IN(4), .NUM_CLASSES(3), .DATA_W(8), .WEIGHT_W(8), .ACC_W(8), .RELU(0)) dut2 (
    .clk(clk), .resetn(resetn), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pix_addr(pa2), .pix_data(pd2), .w_row(wr2), .scores(sc2), .class_idx(ci2));

  // pix packs {p3,p2,p1,p0}; each row packs {class2,class1,class0}.
  task automatic set_mem(input logic [31:0] pix, input logic [23:0] r0, r1, r2, r3);
    for (int i = 0; i < 4; i++) pix_mem[i] = pix[i*8 +: 8];
    w_mem[0] = r0; w_mem[1] = r1; w_mem[2] = r2; w_mem[3] = r3;
  endtask

  // Starts instance `which`; lat is the edge index (E0 = start edge) after which done was seen.
  task automatic run(input int which, output int lat, output logic busy_e0);
    lat = -1;
    @(negedge clk); start_v[which] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[which] = 1'b0; busy_e0 = busy_v[which];
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); @(negedge clk);
      if (done_v[which]) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_v = '0;
    repeat (2) @(negedge clk);
    total++; if (busy_v !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b want=000", busy_v); end
    total++; if (done_v !== 3'b000) begin bad++; $display("FAIL reset_done got=%b want=000", done_v); end
    total++; if ({pa0, pa1, pa2} !== 6'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", {pa0, pa1, pa2}); end
    total++; if ({sc0, sc1, sc2} !== '0) begin bad++; $display("FAIL reset_scores got=%h want=0", {sc0, sc1, sc2}); end
    total++; if ({ci0, ci1, ci2} !== 6'd0) begin bad++; $display("FAIL reset_class got=%h want=0", {ci0, ci1, ci2}); end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic b; logic [31:0] exp_s [3];
    set_mem(32'h04030201, 24'h00FF01, 24'h000001, 24'h000001, 24'h000201);
    exp_s[0] = 32'd10; exp_s[1] = 32'd7; exp_s[2] = 32'd0;
    run(0, lat, b);
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
    total++; if (b !== 1'b1) begin bad++; $display("FAIL basic_busy_after_start got=%b want=1", b); end
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy_v[0]); end
    for (int c = 0; c < 3; c++) begin
      total++;
      if (sc0[c*32 +: 32] !== exp_s[c]) begin bad++; $display("FAIL basic_score%0d got=%0d want=%0d", c, $signed(sc0[c*32 +: 32]), $signed(exp_s[c])); end
    end
    total++; if (ci0 !== 2'd0) begin bad++; $display("FAIL basic_class got=%0d want=0", ci0); end
    @(negedge clk);
    total++; if (done_v[0] !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done_v[0]); end
    total++; if (sc0[31:0] !== 32'd10) begin bad++; $display("FAIL basic_score_hold got=%0d want=10", sc0[31:0]); end
  endtask

  task automatic test_argmax();
    int lat; logic b;
    set_mem(32'h00000005, 24'h010101, 24'h000000, 24'h000000, 24'h000000);
    run(0, lat, b);
    total++; if (sc0 !== {32'd5, 32'd5, 32'd5}) begin bad++; $display("FAIL tie555_scores got=%h want=5,5,5", sc0); end
    total++; if (ci0 !== 2'd0) begin bad++; $display("FAIL tie555_class got=%0d want=0", ci0); end
    set_mem(32'h00000303, 24'h030101, 24'h000200, 24'h000000, 24'h000000);
    run(0, lat, b);
    total++; if (sc0 !== {32'd9, 32'd9, 32'd3}) begin bad++; $display("FAIL tie399_scores got=%h want=3,9,9", sc0); end
    total++; if (ci0 !== 2'd1) begin bad++; $display("FAIL tie399_class got=%0d want=1", ci0); end
    set_mem(32'h00000001, 24'h02FDFB, 24'h000000, 24'h000000, 24'h000000);
    run(0, lat, b);
    total++; if (sc0 !== {32'd2, 32'hFFFFFFFD, 32'hFFFFFFFB}) begin bad++; $display("FAIL neg_scores got=%h want=-5,-3,2", sc0); end
    total++; if (ci0 !== 2'd2) begin bad++; $display("FAIL neg_class got=%0d want=2", ci0); end
  endtask

  task automatic test_relu();
    int lat; logic b;
    set_mem(32'hFFFFFFFF, 24'h018000, 24'h018000, 24'h018000, 24'h018000);
    run(1, lat, b);
    total++; if (lat !== 9) begin bad++; $display("FAIL relu_latency got=%0d want=9", lat); end
    total++; if (sc1 !== {32'd1020, 32'd0, 32'd0}) begin bad++; $display("FAIL relu_scores got=%h want=0,0,1020", sc1); end
    total++; if (ci1 !== 2'd2) begin bad++; $display("FAIL relu_class got=%0d want=2", ci1); end
    run(0, lat, b);
    total++; if (sc0[63:32] !== 32'hFFFE0200) begin bad++; $display("FAIL norelu_score1 got=%0d want=-130560", $signed(sc0[63:32])); end
    total++; if (ci0 !== 2'd2) begin bad++; $display("FAIL norelu_class got=%0d want=2", ci0); end
    set_mem(32'hFFFFFFFF, 24'h80FFFE, 24'h80FFFE, 24'h80FFFE, 24'h80FFFE);
    run(1, lat, b);
    total++; if (sc1 !== '0) begin bad++; $display("FAIL relu_allneg_scores got=%h want=0", sc1); end
    total++; if (ci1 !== 2'd0) begin bad++; $display("FAIL relu_allneg_class got=%0d want=0", ci1); end
    run(0, lat, b);
    total++; if (sc0[63:32] !== 32'hFFFFFC04) begin bad++; $display("FAIL norelu_allneg_score1 got=%0d want=-1020", $signed(sc0[63:32])); end
    total++; if (ci0 !== 2'd1) begin bad++; $display("FAIL norelu_allneg_class got=%0d want=1", ci0); end
  endtask

  task automatic test_wrap();
    int lat; logic b;
    set_mem(32'h0000FFFF, 24'h000001, 24'h000001, 24'h000000, 24'h000000);
    run(2, lat, b);
    total++; if (sc2[7:0] !== 8'hFE) begin bad++; $display("FAIL wrap_score0 got=%0d want=254", sc2[7:0]); end
    total++; if (ci2 !== 2'd1) begin bad++; $display("FAIL wrap_class got=%0d want=1", ci2); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic b;
    set_mem(32'h00000303, 24'h030101, 24'h000200, 24'h000000, 24'h000000);
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy_v[0]); end
    total++; if (done_v[0] !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", done_v[0]); end
    total++; if (pa0 !== 2'd0) begin bad++; $display("FAIL midreset_addr got=%0d want=0", pa0); end
    total++; if (sc0 !== '0) begin bad++; $display("FAIL midreset_scores got=%h want=0", sc0); end
    total++; if (ci0 !== 2'd0) begin bad++; $display("FAIL midreset_class got=%0d want=0", ci0); end
    @(negedge clk); resetn = 1'b1;
    set_mem(32'h04030201, 24'h00FF01, 24'h000001, 24'h000001, 24'h000201);
    run(0, lat, b);
    total++; if (lat !== 9) begin bad++; $display("FAIL midreset_rerun_latency got=%0d want=9", lat); end
    total++; if (sc0 !== {32'd0, 32'd7, 32'd10}) begin bad++; $display("FAIL midreset_rerun_scores got=%h want=10,7,0", sc0); end
  endtask

  task automatic test_start_ignored();
    int n; int first;
    n = 0; first = -1;
    set_mem(32'h04030201, 24'h00FF01, 24'h000001, 24'h000001, 24'h000201);
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 2) start_v[0] = 1'b1;
      if (k == 3) start_v[0] = 1'b0;
      if (done_v[0]) begin n++; if (first < 0) first = k; end
    end
    total++; if (n !== 1) begin bad++; $display("FAIL ignored_done_count got=%0d want=1", n); end
    total++; if (first !== 9) begin bad++; $display("FAIL ignored_latency got=%0d want=9", first); end
    total++; if (sc0 !== {32'd0, 32'd7, 32'd10}) begin bad++; $display("FAIL ignored_scores got=%h want=10,7,0", sc0); end
  endtask

  task automatic test_back_to_back();
    int n; int d1; int d2;
    n = 0; d1 = -1; d2 = -1;
    set_mem(32'h04030201, 24'h00FF01, 24'h000001, 24'h000001, 24'h000201);
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 15) start_v[0] = 1'b0;
      if (done_v[0]) begin
        n++;
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
    end
    total++; if (n !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", n); end
    total++; if (d1 !== 9) begin bad++; $display("FAIL b2b_first_done got=%0d want=9", d1); end
    total++; if (d2 !== 20) begin bad++; $display("FAIL b2b_second_done got=%0d want=20", d2); end
    total++; if (sc0 !== {32'd0, 32'd7, 32'd10}) begin bad++; $display("FAIL b2b_scores got=%h want=10,7,0", sc0); end
    total++; if (ci0 !== 2'd0) begin bad++; $display("FAIL b2b_class got=%0d want=0", ci0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_argmax();
    test_relu();
    test_wrap();
    test_reset_mid_run();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
